// File: rtl/rc4_stream_ctrl.sv
// Sequences the rc4 core (key schedule, optional RC4-drop, per-byte pull) and XORs keystream onto plaintext.
// Plaintext accept -> ciphertext valid is one cycle; s_ready drops while the output register is stalled.
module rc4_stream_ctrl #(
  parameter int unsigned DROP_N  = 0,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [31:0] cfg_key,
  input  logic [7:0]  cfg_key_len,
  input  logic [15:0] cfg_msg_len,
  input  logic        abort,
  output logic        core_start,
  output logic [31:0] core_key,
  output logic [7:0]  core_key_len,
  output logic        ks_req,
  input  logic        ks_valid,
  input  logic [7:0]  ks_byte,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, INIT, DROP, RUN, FLUSH} state_t;

  state_t        state;
  logic [15:0]   bytes_left;
  logic [15:0]   drop_cnt;
  logic [7:0]    kbuf;
  logic          kbuf_full;
  logic [WW-1:0] wait_cnt;
  logic          ks_take;
  logic          accept;
  logic          key_len_ok;
  logic          timeout_hit;

  assign ks_take     = ks_req & ks_valid;
  assign s_ready     = kbuf_full & (bytes_left != 16'd0) & (~m_valid | m_ready);
  assign accept      = s_valid & s_ready;
  assign busy        = (state != IDLE);
  assign key_len_ok  = (cfg_key_len != 8'd0) && (cfg_key_len <= 8'd4);
  // Fires on the TIMEOUT-th consecutive cycle of an unanswered request.
  assign timeout_hit = ks_req & ~ks_valid & (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      core_start   <= 1'b0;
      core_key     <= '0;
      core_key_len <= '0;
      ks_req       <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      kbuf         <= '0;
      kbuf_full    <= 1'b0;
      bytes_left   <= '0;
      drop_cnt     <= '0;
      wait_cnt     <= '0;
    end else begin
      done     <= 1'b0;
      wait_cnt <= (ks_req && !ks_valid) ? wait_cnt + WW'(1) : '0;
      if (state != IDLE && (abort || timeout_hit)) begin
        state      <= IDLE;
        core_start <= 1'b0;
        ks_req     <= 1'b0;
        m_valid    <= 1'b0;
        m_last     <= 1'b0;
        kbuf_full  <= 1'b0;
        bytes_left <= '0;
        drop_cnt   <= '0;
        wait_cnt   <= '0;
        if (!abort) err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_start) begin
              core_key     <= cfg_key;
              core_key_len <= cfg_key_len;
              bytes_left   <= cfg_msg_len;
              err          <= ~key_len_ok;
              if (key_len_ok) begin
                state      <= INIT;
                core_start <= 1'b1;
              end
            end
          end
          INIT: begin
            drop_cnt <= 16'(DROP_N);
            if (DROP_N != 0) begin
              state  <= DROP;
              ks_req <= 1'b1;
            end else if (bytes_left == 16'd0) begin
              state <= FLUSH;
            end else begin
              state <= RUN;
            end
          end
          DROP: begin
            if (ks_take) begin
              ks_req <= 1'b0;
              if (drop_cnt != 16'd0) drop_cnt <= drop_cnt - 16'd1;
              if (drop_cnt <= 16'd1) state <= (bytes_left == 16'd0) ? FLUSH : RUN;
            end else begin
              ks_req <= 1'b1;
            end
          end
          RUN: begin
            // Request for the next byte is raised straight from the accept so the core sees no idle gap.
            if (ks_take) begin
              kbuf      <= ks_byte;
              kbuf_full <= 1'b1;
              ks_req    <= 1'b0;
            end else if (accept) begin
              kbuf_full  <= 1'b0;
              bytes_left <= bytes_left - 16'd1;
              ks_req     <= (bytes_left > 16'd1);
            end else if (!kbuf_full && bytes_left != 16'd0) begin
              ks_req <= 1'b1;
            end
            if (accept) begin
              m_valid <= 1'b1;
              m_data  <= s_data ^ kbuf;
              m_last  <= (bytes_left == 16'd1);
            end else if (m_ready) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end
            if (bytes_left == 16'd0) state <= FLUSH;
          end
          FLUSH: begin
            if (m_ready) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end
            if (!m_valid) begin
              done       <= 1'b1;
              core_start <= 1'b0;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Directed bench for rc4_stream_ctrl: three instances (DROP_N 0/3/2) each fed by a small keystream core model.
`timescale 1ns/1ps
module tb_rc4_stream_ctrl;

  localparam int NI = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NI-1:0]        cfg_start;
  logic [31:0]          cfg_key;
  logic [7:0]           cfg_key_len;
  logic [15:0]          cfg_msg_len;
  logic                 abort;
  logic [NI-1:0]        core_start;
  logic [NI-1:0][31:0]  core_key;
  logic [NI-1:0][7:0]   core_key_len;
  logic [NI-1:0]        ks_req;
  logic [NI-1:0]        ks_valid;
  logic [NI-1:0][7:0]   ks_byte;
  logic [NI-1:0]        stall;
  logic                 s_valid;
  logic [7:0]           s_data;
  logic [NI-1:0]        s_ready;
  logic [NI-1:0]        m_valid;
  logic [NI-1:0][7:0]   m_data;
  logic [NI-1:0]        m_last;
  logic                 m_ready;
  logic [NI-1:0]        busy;
  logic [NI-1:0]        done;
  logic [NI-1:0]        err;

  logic [7:0] ks_tab [12] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34,
                              8'hCA, 8'h72, 8'hA7, 8'h19, 8'h4A, 8'h28};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic       kv;
    logic [7:0] kb;
    int         idx;

    rc4_stream_ctrl #(.DROP_N(g == 1 ? 3 : (g == 2 ? 2 : 0)), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start[g]), .cfg_key(cfg_key),
      .cfg_key_len(cfg_key_len), .cfg_msg_len(cfg_msg_len), .abort(abort),
      .core_start(core_start[g]), .core_key(core_key[g]), .core_key_len(core_key_len[g]),
      .ks_req(ks_req[g]), .ks_valid(ks_valid[g]), .ks_byte(ks_byte[g]),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready[g]),
      .m_valid(m_valid[g]), .m_data(m_data[g]), .m_last(m_last[g]), .m_ready(m_ready),
      .busy(busy[g]), .done(done[g]), .err(err[g])
    );

    // Core model: answers a request one cycle after seeing it, restarts its stream when core_start drops.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        kv  <= 1'b0;
        kb  <= 8'h00;
        idx <= 0;
      end else begin
        kv <= ks_req[g] && !kv && !stall[g];
        if (ks_req[g] && !kv && !stall[g]) begin
          kb  <= ks_tab[idx % 12];
          idx <= idx + 1;
        end
        if (!core_start[g]) idx <= 0;
      end
    end
    assign ks_valid[g] = kv;
    assign ks_byte[g]  = kb;
  end

  typedef struct {
    logic [7:0] pt;
    logic [7:0] ct_d0;
    logic [7:0] ct_d3;
    logic       last;
  } vec_t;
  vec_t tab [9];

  int n_cmp = 0;
  int n_fail = 0;

  int act;
  logic [7:0] cap_d [$];
  logic       cap_l [$];
  int ks_used, done_cnt, mv_seen, cs_seen, req_seen, viol, done_busy_bad;
  logic hold, hold_l, prev_busy, accepted, pend;
  logic [7:0] hold_d;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic reset_mon();
    cap_d.delete();
    cap_l.delete();
    ks_used = 0; done_cnt = 0; mv_seen = 0; cs_seen = 0; req_seen = 0;
    viol = 0; done_busy_bad = 0;
    hold = 1'b0; hold_l = 1'b0; hold_d = 8'h00; prev_busy = 1'b0;
    accepted = 1'b0; pend = 1'b0;
  endtask

  // Samples the active instance mid-cycle, then returns just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    accepted = s_valid && s_ready[act];
    if (m_valid[act] && m_ready) begin
      cap_d.push_back(m_data[act]);
      cap_l.push_back(m_last[act]);
    end
    if (hold && (!m_valid[act] || m_data[act] !== hold_d || m_last[act] !== hold_l)) viol++;
    if (m_valid[act] && !m_ready && s_ready[act]) viol++;
    hold   = m_valid[act] && !m_ready;
    hold_d = m_data[act];
    hold_l = m_last[act];
    if (ks_req[act] && ks_valid[act]) ks_used++;
    if (ks_req[act]) req_seen++;
    pend = ks_req[act] && !ks_valid[act];
    if (done[act]) begin
      done_cnt++;
      if (busy[act] || !prev_busy) done_busy_bad++;
    end
    prev_busy = busy[act];
    if (m_valid[act]) mv_seen++;
    if (core_start[act]) cs_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int a, input logic [7:0] klen, input logic [15:0] mlen);
    act = a;
    reset_mon();
    cfg_key     = 32'h0079654B;
    cfg_key_len = klen;
    cfg_msg_len = mlen;
    cfg_start   = '0;
    cfg_start[a] = 1'b1;
    tick();
    cfg_start = '0;
  endtask

  task automatic run_msg(input int n, input bit bp, input int budget, input string name);
    int pi = 0;
    int c = 0;
    logic [15:0] lfsr = 16'hACE1;
    while (done_cnt == 0 && !err[act] && c < budget) begin
      s_valid = (pi < n);
      s_data  = tab[pi < 9 ? pi : 8].pt;
      if (bp) begin
        lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        m_ready = lfsr[0];
      end else begin
        m_ready = 1'b1;
      end
      tick();
      if (accepted) pi++;
      c++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check({name, "_in_budget"}, c < budget, 1'b1);
  endtask

  task automatic check_out(input bit drop3, input string name);
    logic [7:0] got_d;
    logic       got_l;
    check({name, "_count"}, cap_d.size(), 9);
    for (int i = 0; i < 9; i++) begin
      got_d = (i < cap_d.size()) ? cap_d[i] : 8'hxx;
      got_l = (i < cap_l.size()) ? cap_l[i] : 1'bx;
      check($sformatf("%s_data%0d", name, i), got_d, drop3 ? tab[i].ct_d3 : tab[i].ct_d0);
      check($sformatf("%s_last%0d", name, i), got_l, tab[i].last);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tab[0] = '{8'h50, 8'hBB, 8'hD1, 1'b0};
    tab[1] = '{8'h6C, 8'hF3, 8'hDB, 1'b0};
    tab[2] = '{8'h61, 8'h16, 8'h55, 1'b0};
    tab[3] = '{8'h69, 8'hE8, 8'hA3, 1'b0};
    tab[4] = '{8'h6E, 8'hD9, 8'h1C, 1'b0};
    tab[5] = '{8'h74, 8'h40, 8'hD3, 1'b0};
    tab[6] = '{8'h65, 8'hAF, 8'h7C, 1'b0};
    tab[7] = '{8'h78, 8'h0A, 8'h32, 1'b0};
    tab[8] = '{8'h74, 8'hD3, 8'h5C, 1'b1};

    rst_n = 1'b0;
    cfg_start = '0; cfg_key = '0; cfg_key_len = '0; cfg_msg_len = '0;
    abort = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; stall = '0;
    act = 0;
    reset_mon();

    #12;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_ctl%0d", i),
            {core_start[i], ks_req[i], s_ready[i], m_valid[i], m_last[i], busy[i], done[i], err[i]}, 8'h00);
      check($sformatf("reset_data%0d", i), {m_data[i], core_key_len[i]}, 16'h0000);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", {busy, core_start, err}, '0);

    // Known vector, no drop.
    start(0, 8'd3, 16'd9);
    run_msg(9, 1'b0, 300, "known");
    check_out(1'b0, "known");
    check("known_ks_used", ks_used, 9);
    check("known_done", done_cnt, 1);
    check("known_err", err[0], 1'b0);
    check("known_core_key", core_key[0], 32'h0079654B);
    check("known_core_klen", core_key_len[0], 8'd3);

    // RC4-drop of three bytes.
    start(1, 8'd3, 16'd9);
    run_msg(9, 1'b0, 300, "drop");
    check_out(1'b1, "drop");
    check("drop_ks_used", ks_used, 12);
    check("drop_done", done_cnt, 1);

    // Downstream backpressure.
    start(0, 8'd3, 16'd9);
    run_msg(9, 1'b1, 600, "bp");
    check_out(1'b0, "bp");
    check("bp_stability", viol, 0);
    check("bp_done", done_cnt, 1);

    // Illegal key lengths, then recovery.
    start(0, 8'd0, 16'd9);
    for (int i = 0; i < 4; i++) tick();
    check("klen0_err", err[0], 1'b1);
    check("klen0_busy_cs", {busy[0], cs_seen[7:0]}, 9'd0);
    start(0, 8'd5, 16'd9);
    for (int i = 0; i < 4; i++) tick();
    check("klen5_err", err[0], 1'b1);
    check("klen5_busy_cs", {busy[0], cs_seen[7:0]}, 9'd0);
    start(0, 8'd4, 16'd9);
    check("legal_err_clear", {err[0], busy[0]}, 2'b01);
    run_msg(9, 1'b0, 300, "legal");
    check_out(1'b0, "legal");
    check("legal_done", done_cnt, 1);

    // Stalled core -> timeout.
    stall[0] = 1'b1;
    start(0, 8'd3, 16'd9);
    run_msg(9, 1'b0, 100, "tmo");
    check("tmo_err", err[0], 1'b1);
    check("tmo_req_cycles", req_seen, TO);
    check("tmo_idle", {busy[0], core_start[0], ks_req[0], m_valid[0]}, 4'b0000);
    check("tmo_no_done", done_cnt, 0);
    stall[0] = 1'b0;

    // Abort mid-RUN coinciding with a keystream strobe.
    start(0, 8'd3, 16'd9);
    begin
      int pi = 0;
      int c = 0;
      while (!(cap_d.size() >= 3 && pend) && c < 100) begin
        s_valid = (pi < 9);
        s_data  = tab[pi < 9 ? pi : 8].pt;
        tick();
        if (accepted) pi++;
        c++;
      end
      s_valid = 1'b0;
      check("abort_reached", c < 100, 1'b1);
    end
    check("abort_with_ksv", {ks_req[0], ks_valid[0], busy[0]}, 3'b111);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {busy[0], core_start[0], ks_req[0], m_valid[0], s_ready[0], err[0]}, 6'd0);
    reset_mon();
    for (int i = 0; i < 8; i++) tick();
    check("abort_quiet", {done_cnt[7:0], mv_seen[7:0], cs_seen[7:0]}, 24'd0);
    start(0, 8'd3, 16'd9);
    run_msg(9, 1'b0, 300, "after_abort");
    check_out(1'b0, "after_abort");

    // Zero-length message with a two-byte drop.
    start(2, 8'd3, 16'd0);
    run_msg(0, 1'b0, 100, "zero");
    check("zero_ks_used", ks_used, 2);
    check("zero_no_mvalid", mv_seen, 0);
    check("zero_done", done_cnt, 1);
    check("zero_busy_falls", done_busy_bad, 0);
    check("zero_err", err[2], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
